// File: rtl/sample_rate_gen_if.sv
// Control and timing bundle for sample_rate_gen.
// The resync line exists only when SRG_RESYNC_EN is defined.
interface sample_rate_gen_if #(
    parameter int CNT_W  = 12,
    parameter int NUM_CH = 2
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             en;
    logic [CNT_W-1:0] div_in;
    logic             div_load;
`ifdef SRG_RESYNC_EN
    logic             resync;
`endif
    logic             div_pending;
    logic             div_err;
    logic [CNT_W-1:0] phase;
    logic             sample_tick;
    logic             sample_clk;
    logic             ch_tick;
    logic [CH_W-1:0]  ch_idx;

    modport master (
`ifdef SRG_RESYNC_EN
        output resync,
`endif
        output en, div_in, div_load,
        input  div_pending, div_err, phase, sample_tick, sample_clk, ch_tick, ch_idx
    );

    modport slave (
`ifdef SRG_RESYNC_EN
        input  resync,
`endif
        input  en, div_in, div_load,
        output div_pending, div_err, phase, sample_tick, sample_clk, ch_tick, ch_idx
    );
endinterface

// File: rtl/sample_rate_gen.sv
// Sample-rate timing generator: divides clk_audio_12M288 by a runtime-loadable
// divisor N and produces a sample strobe, a square sample clock and TDM slot
// strobes. Optional phase realignment via resync when SRG_RESYNC_EN is defined.
module sample_rate_gen #(
    parameter int CNT_W       = 12,
    parameter int DEFAULT_DIV = 256,
    parameter int NUM_CH      = 2
) (
    input  logic             clk_audio_12M288,
    input  logic             rst_n,
    sample_rate_gen_if.slave srg
);
    localparam int               LOG2_CH  = (NUM_CH > 1) ? $clog2(NUM_CH) : 0;
    localparam int               CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2 * NUM_CH);
    localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DEF_SLOT = CNT_W'(DEFAULT_DIV >> LOG2_CH);

    logic [CNT_W-1:0] phase_q,    phase_d;
    logic [CNT_W-1:0] div_q,      div_d;
    logic [CNT_W-1:0] slot_q,     slot_d;
    logic [CNT_W-1:0] pend_div_q, pend_div_d;
    logic             div_pending_q, div_pending_d;
    logic             div_err_q,     div_err_d;
    logic             sample_tick_q, sample_tick_d;
    logic             sample_clk_q,  sample_clk_d;
    logic             ch_tick_q,     ch_tick_d;
    logic [CH_W-1:0]  ch_idx_q,      ch_idx_d;

    logic             load_ok;
    logic             restart;
    logic [CNT_W-1:0] slot_pos;

    // A load is accepted only if every slot gets at least two cycles
    assign load_ok = srg.div_load && (srg.div_in >= MIN_DIV);

    // Next-state: period restart (wrap or resync), idle-time load, or normal count
    always_comb begin
        phase_d       = phase_q;
        div_d         = div_q;
        slot_d        = slot_q;
        pend_div_d    = pend_div_q;
        div_pending_d = div_pending_q;
        div_err_d     = srg.div_load && !load_ok;
        sample_tick_d = 1'b0;
        ch_tick_d     = 1'b0;
        ch_idx_d      = ch_idx_q;
        slot_pos      = slot_q;
        restart       = srg.en && (phase_q >= div_q - 1'b1);
`ifdef SRG_RESYNC_EN
        restart       = restart || srg.resync;
`endif
        if (restart) begin
            phase_d       = '0;
            sample_tick_d = 1'b1;
            ch_tick_d     = 1'b1;
            ch_idx_d      = '0;
            if (div_pending_q) begin
                div_d         = pend_div_q;
                slot_d        = pend_div_q >> LOG2_CH;
                div_pending_d = 1'b0;
            end
            if (load_ok) begin
                pend_div_d    = srg.div_in;
                div_pending_d = 1'b1;
            end
        end else if (!srg.en) begin
            if (load_ok) begin
                div_d         = srg.div_in;
                slot_d        = srg.div_in >> LOG2_CH;
                phase_d       = '0;
                div_pending_d = 1'b0;
            end
        end else begin
            phase_d = phase_q + 1'b1;
            if (load_ok) begin
                pend_div_d    = srg.div_in;
                div_pending_d = 1'b1;
            end
            for (int k = 1; k < NUM_CH; k++) begin
                if (phase_d == slot_pos) begin
                    ch_tick_d = 1'b1;
                    ch_idx_d  = CH_W'(k);
                end
                slot_pos = slot_pos + slot_q;
            end
        end
        sample_clk_d = (phase_d >= (div_d >> 1));
    end

    // State and registered outputs; reset discards any pending divisor
    always_ff @(posedge clk_audio_12M288 or negedge rst_n) begin
        if (!rst_n) begin
            phase_q       <= '0;
            div_q         <= DEF_DIV;
            slot_q        <= DEF_SLOT;
            pend_div_q    <= DEF_DIV;
            div_pending_q <= 1'b0;
            div_err_q     <= 1'b0;
            sample_tick_q <= 1'b0;
            sample_clk_q  <= 1'b0;
            ch_tick_q     <= 1'b0;
            ch_idx_q      <= '0;
        end else begin
            phase_q       <= phase_d;
            div_q         <= div_d;
            slot_q        <= slot_d;
            pend_div_q    <= pend_div_d;
            div_pending_q <= div_pending_d;
            div_err_q     <= div_err_d;
            sample_tick_q <= sample_tick_d;
            sample_clk_q  <= sample_clk_d;
            ch_tick_q     <= ch_tick_d;
            ch_idx_q      <= ch_idx_d;
        end
    end

    assign srg.phase       = phase_q;
    assign srg.div_pending = div_pending_q;
    assign srg.div_err     = div_err_q;
    assign srg.sample_tick = sample_tick_q;
    assign srg.sample_clk  = sample_clk_q;
    assign srg.ch_tick     = ch_tick_q;
    assign srg.ch_idx      = ch_idx_q;
endmodule

// File: tb/tb_sample_rate_gen.sv
// Testbench for sample_rate_gen: directed scenarios plus random traffic,
// compared every cycle against a period/slot arithmetic model.
module tb_sample_rate_gen;
    localparam int CNT_W       = 12;
    localparam int DEFAULT_DIV = 256;
    localparam int NUM_CH      = 2;

    logic clk_audio_12M288 = 1'b0;
    logic rst_n            = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int last_tick   = 0;

    // Reference model state
    int m_phase;
    int m_div;
    int m_pend;
    bit m_pend_valid;
    int m_idx;
    bit e_tick;
    bit e_ch_tick;
    bit e_err;
    bit e_clk;

    sample_rate_gen_if #(.CNT_W(CNT_W), .NUM_CH(NUM_CH)) srg_bus ();

    sample_rate_gen #(
        .CNT_W      (CNT_W),
        .DEFAULT_DIV(DEFAULT_DIV),
        .NUM_CH     (NUM_CH)
    ) dut (
        .clk_audio_12M288(clk_audio_12M288),
        .rst_n           (rst_n),
        .srg             (srg_bus)
    );

    // 12.288 MHz stand-in clock
    always #5 clk_audio_12M288 = ~clk_audio_12M288;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_output({tag, ".phase"},       32'(srg_bus.phase),       32'(m_phase));
        check_output({tag, ".sample_tick"}, 32'(srg_bus.sample_tick), 32'(e_tick));
        check_output({tag, ".sample_clk"},  32'(srg_bus.sample_clk),  32'(e_clk));
        check_output({tag, ".ch_tick"},     32'(srg_bus.ch_tick),     32'(e_ch_tick));
        check_output({tag, ".ch_idx"},      32'(srg_bus.ch_idx),      32'(m_idx));
        check_output({tag, ".div_pending"}, 32'(srg_bus.div_pending), 32'(m_pend_valid));
        check_output({tag, ".div_err"},     32'(srg_bus.div_err),     32'(e_err));
    endtask

    task automatic model_reset();
        m_phase      = 0;
        m_div        = DEFAULT_DIV;
        m_pend       = 0;
        m_pend_valid = 1'b0;
        m_idx        = 0;
        e_tick       = 1'b0;
        e_ch_tick    = 1'b0;
        e_err        = 1'b0;
        e_clk        = 1'b0;
    endtask

    // One clock of the behavioural rules: period N, slots at multiples of N/NUM_CH
    task automatic model_step(input bit en, input bit load, input int din, input bit rs);
        int  dv;
        int  s;
        bit  legal;
        bit  wrap;
        dv        = din & ((1 << CNT_W) - 1);
        legal     = load && (dv >= 2 * NUM_CH);
        e_err     = load && !legal;
        e_tick    = 1'b0;
        e_ch_tick = 1'b0;
        wrap      = en && (m_phase + 1 == m_div);
        if (rs || wrap) begin
            m_phase = 0;
            if (m_pend_valid) begin
                m_div        = m_pend;
                m_pend_valid = 1'b0;
            end
            e_tick    = 1'b1;
            e_ch_tick = 1'b1;
            m_idx     = 0;
            if (legal) begin
                m_pend       = dv;
                m_pend_valid = 1'b1;
            end
        end else if (!en) begin
            if (legal) begin
                m_div        = dv;
                m_phase      = 0;
                m_pend_valid = 1'b0;
            end
        end else begin
            m_phase++;
            if (legal) begin
                m_pend       = dv;
                m_pend_valid = 1'b1;
            end
            s = m_div / NUM_CH;
            if ((m_phase % s) == 0 && (m_phase / s) < NUM_CH) begin
                e_ch_tick = 1'b1;
                m_idx     = m_phase / s;
            end
        end
        e_clk = (m_phase >= m_div / 2);
    endtask

    task automatic apply_stimulus(input bit en, input bit load, input int din, input bit rs);
        bit rs_eff;
        @(negedge clk_audio_12M288);
        srg_bus.en       = en;
        srg_bus.div_load = load;
        srg_bus.div_in   = din[CNT_W-1:0];
`ifdef SRG_RESYNC_EN
        srg_bus.resync   = rs;
        rs_eff           = rs;
`else
        rs_eff           = 1'b0;
`endif
        model_step(en, load, din, rs_eff);
        @(posedge clk_audio_12M288);
        #1;
        cyc++;
        if (srg_bus.sample_tick === 1'b1) last_tick = cyc;
        check_all("cycle");
    endtask

    task automatic set_idle();
        srg_bus.en       = 1'b0;
        srg_bus.div_load = 1'b0;
        srg_bus.div_in   = '0;
`ifdef SRG_RESYNC_EN
        srg_bus.resync   = 1'b0;
`endif
    endtask

    task automatic run_to_phase(input int target);
        for (int i = 0; i < 5000 && m_phase != target; i++) apply_stimulus(1'b1, 1'b0, 0, 1'b0);
        check_output("reach_phase", 32'(srg_bus.phase), 32'(target));
    endtask

    task automatic run_until_tick(output int n);
        n = 0;
        for (int i = 0; i < 5000; i++) begin
            apply_stimulus(1'b1, 1'b0, 0, 1'b0);
            n++;
            if (srg_bus.sample_tick === 1'b1) break;
        end
    endtask

    task automatic measure_period(input string tag, input int exp);
        int prev;
        int n;
        prev = last_tick;
        run_until_tick(n);
        check_output(tag, 32'(last_tick - prev), 32'(exp));
    endtask

    task automatic pulse_reset(input int hold_ns);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        set_idle();
        #(hold_ns);
        @(negedge clk_audio_12M288);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int dv;
        set_idle();
        model_reset();
        #2;
        pulse_reset(20);

        // Defaults: first tick on edge 256, then every 256
        run_until_tick(n);
        check_output("first_tick_edge", 32'(n), 32'(256));
        measure_period("default_period", 256);

        // Load 255 at phase 100: this period stays 256, next is 255
        run_to_phase(100);
        apply_stimulus(1'b1, 1'b1, 255, 1'b0);
        measure_period("period_before_load", 256);
        measure_period("period_after_load", 255);

        // Restore 256, then illegal loads leave it untouched
        run_to_phase(10);
        apply_stimulus(1'b1, 1'b1, 256, 1'b0);
        measure_period("period_restore", 255);
        run_to_phase(10);
        apply_stimulus(1'b1, 1'b1, 3, 1'b0);
        run_to_phase(20);
        apply_stimulus(1'b1, 1'b1, 0, 1'b0);
        measure_period("period_illegal", 256);

        // Ten disabled cycles at phase 50 stretch the period by ten
        run_to_phase(50);
        for (int i = 0; i < 10; i++) apply_stimulus(1'b0, 1'b0, 0, 1'b0);
        measure_period("period_stretched", 266);
        measure_period("period_after_stretch", 256);

`ifdef SRG_RESYNC_EN
        // Resync at phase 100 applies pending 200 immediately
        run_to_phase(80);
        apply_stimulus(1'b1, 1'b1, 200, 1'b0);
        run_to_phase(100);
        apply_stimulus(1'b1, 1'b0, 0, 1'b1);
        measure_period("period_after_resync", 200);
`endif

        // Load while disabled applies at once with phase cleared
        apply_stimulus(1'b0, 1'b1, 40, 1'b0);
        run_until_tick(n);
        check_output("idle_load_period", 32'(n), 32'(40));

        // Random traffic with frequent short divisors
        for (int i = 0; i < 3000; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: dv = int'($urandom_range(0, 24));
                5, 6, 7:       dv = int'($urandom_range(4, 64));
                default:       dv = int'($urandom_range(0, 4095));
            endcase
            apply_stimulus($urandom_range(0, 9) != 0, $urandom_range(0, 14) == 0, dv,
                           $urandom_range(0, 59) == 0);
        end

        // Reset mid-period with a pending divisor discards it
        apply_stimulus(1'b0, 1'b1, 256, 1'b0);
        run_to_phase(170);
        apply_stimulus(1'b1, 1'b1, 300, 1'b0);
        run_to_phase(180);
        @(negedge clk_audio_12M288);
        #2;
        pulse_reset(10);
        run_until_tick(n);
        check_output("period_after_reset", 32'(n), 32'(256));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sample_rate_gen.md
# sample_rate_gen

Parametrised sample-rate timing generator that replaces the fixed divide-by-256 ADC clock. It derives the sample period from `clk_audio_12M288` using a runtime-loadable divisor, and emits a one-cycle sample strobe, a near-50% square sample clock and per-channel TDM slot strobes. It sits at the head of the FIR chain and feeds the input capture and the multi-channel MAC sequencer.

## Interface
- `CNT_W`, 12: width of the phase counter and divisor.
- `DEFAULT_DIV`, 256: divisor after reset (12.288 MHz / 256 = 48 kHz).
- `NUM_CH`, 2: TDM channel slots per sample period. Must be a power of two, ≥1.
- `clk_audio_12M288` in 1: audio PLL clock; the only clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: count enable.
- `div_in` in CNT_W: requested divisor N.
- `div_load` in 1: one-cycle load request for `div_in`.
- `resync` in 1: phase realign pulse; present only with `SRG_RESYNC_EN`.
- `div_pending` out 1: a legal divisor is waiting to be applied.
- `div_err` out 1: one-cycle pulse when a load is rejected.
- `phase` out CNT_W: current position in the period, 0..N-1.
- `sample_tick` out 1: one-cycle strobe per period.
- `sample_clk` out 1: square sample clock.
- `ch_tick` out 1: one-cycle slot strobe.
- `ch_idx` out log2(NUM_CH), minimum 1 bit: slot index qualified by `ch_tick`.

## Operation
- Reset values: `phase`=0, active N=`DEFAULT_DIV`, slot spacing S=`DEFAULT_DIV`>>log2(NUM_CH). All 1-bit outputs are 0, and `ch_idx`=0.
- Counting:
  - While `en`=1, `phase` increments by 1 per cycle. A wrap is the step N-1 → 0.
  - While `en`=0, `phase` and `sample_clk` hold, and `sample_tick`/`ch_tick` are 0.
- `sample_tick` is high exactly in the cycle where `phase` shows 0 after a wrap. It is never asserted after reset without a wrap.
- `sample_clk` is 0 for `phase` < N>>1 and 1 otherwise. This gives low for floor(N/2) cycles and high for ceil(N/2) cycles.
- `ch_tick`:
  - Slot 0 coincides with `sample_tick`.
  - Slot k (1..NUM_CH-1) is high in the cycle where `phase`==k·S, with `ch_idx`=k.
  - `ch_idx` holds its last value between ticks.
- Divisor load:
  - Legal range is 2·NUM_CH ≤ `div_in` ≤ 2^CNT_W-1.
  - An illegal `div_load` pulses `div_err` in the next cycle. The active and pending values are unchanged.
  - A legal load with `en`=1 captures the pending value and sets `div_pending`.
  - The pending value becomes active at the next wrap. That wrap's period-0 cycle already uses the new N and S. `div_pending` clears in the same cycle.
  - Back-to-back loads: the last one wins.
  - A load in the same cycle as a wrap is applied at the following wrap, not this one.
  - A legal load with `en`=0 applies immediately: on the next cycle N and S are updated and `phase`=0. No tick is issued and `div_pending` stays 0.
- Reset asserted mid-period restores all reset values asynchronously. Any pending divisor is discarded.

## Timing
- All outputs are registered and change only on the rising edge of `clk_audio_12M288`.
- With constant `en`=1 after reset, the first `sample_tick` occurs on the N-th enabled edge. It then recurs every N cycles.
- Latency:
  - `div_err` and `div_pending` assert 1 cycle after `div_load`.
  - `resync` takes effect 1 cycle after it is sampled.
- Each `en`=0 cycle stretches the current period by exactly one cycle.

## Configuration
- `SRG_RESYNC_EN` defined:
  - The `resync` port exists.
  - Sampling `resync`=1 (regardless of `en`) forces `phase`=0 and applies any pending divisor. It also asserts `sample_tick` and `ch_tick`/`ch_idx`=0 in the next cycle, exactly as for a wrap.
  - A `div_load` in the same cycle becomes pending for the next wrap.
  - `resync` held high restarts the period every cycle, so `sample_tick` stays high.
- `SRG_RESYNC_EN` undefined: the port is absent and phase is changed only by wrap, reset, or a load while disabled.

## Test plan
- Defaults, `en`=1 after reset → `sample_tick` every 256 cycles, first at edge 256. `sample_clk` low 128 / high 128. `ch_tick` at `phase` 0 (`ch_idx`=0) and 128 (`ch_idx`=1).
- `div_load`=1, `div_in`=255 at `phase`=100 → current period completes at 256 cycles, next period is 255. `div_pending` is high until the wrap. Slot 1 at `phase` 127. `sample_clk` low 127 / high 128.
- `div_in`=3 with NUM_CH=2, and separately `div_in`=0 → `div_err` one-cycle pulse. Period stays 256 and `div_pending` stays 0.
- `en` dropped for 10 cycles at `phase`=50 → `phase` holds at 50 with no ticks. That period measures 266 cycles and the next measures 256.
- `SRG_RESYNC_EN`, `resync` at `phase`=100 with pending 200 → next cycle `phase`=0 with `sample_tick`=1 and `ch_idx`=0. The next tick follows 200 cycles later.
- `rst_n` low at `phase`=180 with a load pending → all outputs are at reset values immediately. After release, the period is 256 and the pending divisor is gone.
